// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: pairs each fetch request's sideband with the
// SRAM data returned a cycle later and hands the entries to decode in order.
module if_id_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned FS_TO_DS_BUS_WD = 65,
  parameter int unsigned DS_BUS_WD       = 97
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       fs_req_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic [31:0]                inst_sram_rdata,
  input  logic                       ds_allowin,
  output logic                       ds_valid,
  output logic [DS_BUS_WD-1:0]       ds_bus,
  output logic                       fs_stall_req
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned ADEF_BIT = 32;
  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  logic                       pend_valid;
  logic [FS_TO_DS_BUS_WD-1:0] pend_info;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;
  logic [CNT_W-1:0]           count;
  logic [DS_BUS_WD-1:0]       mem [DEPTH];

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic [31:0]          inst;
  logic [DS_BUS_WD-1:0] entry;

  // A request that raised ADEF never reaches memory, so its data is replaced by a nop.
  assign inst  = pend_info[ADEF_BIT] ? NOP_INST : inst_sram_rdata;
  assign entry = {pend_info[FS_TO_DS_BUS_WD-1:ADEF_BIT+1], pend_info[ADEF_BIT],
                  inst, pend_info[ADEF_BIT-1:0]};

  assign push  = pend_valid & ~flush;
  assign pop   = ds_valid & ds_allowin;
  assign full  = (count == CNT_W'(DEPTH));
  assign wr_en = resetn & push & (~full | pop);

  assign ds_valid     = (count != '0) & ~flush;
  assign ds_bus       = (count != '0) ? mem[rd_ptr] : '0;
  // Counts the in-flight response as occupied so an issued request always has a slot.
  assign fs_stall_req = ({1'b0, count} + (CNT_W+1)'(pend_valid)) >= (CNT_W+1)'(DEPTH);

  // Sideband of the request whose SRAM data arrives next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_valid <= 1'b0;
      pend_info  <= '0;
    end else begin
      pend_valid <= fs_req_valid & ~flush;
      if (fs_req_valid) begin
        pend_info <= fs_to_ds_bus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= entry;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed and random stimulus for if_id_queue, checked each cycle against a
// queue-based reference model of the fetch/decode decoupling behaviour.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        fs_req_valid;
  logic [64:0] fs_to_ds_bus;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        ds_valid;
  logic [96:0] ds_bus;
  logic        fs_stall_req;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queued entries plus the one outstanding request.
  logic [96:0] mq[$];
  bit          mpv = 1'b0;
  logic [64:0] mpi = '0;

  if_id_queue #(.DEPTH(DEPTH), .FS_TO_DS_BUS_WD(65), .DS_BUS_WD(97)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .fs_req_valid   (fs_req_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_rdata(inst_sram_rdata),
    .ds_allowin     (ds_allowin),
    .ds_valid       (ds_valid),
    .ds_bus         (ds_bus),
    .fs_stall_req   (fs_stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [96:0] obs, input logic [96:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] mkbus(input logic [31:0] csr, input bit adef,
                                        input logic [31:0] pc);
    return {csr, adef, pc};
  endfunction

  function automatic bit m_stall();
    return (mq.size() + int'(mpv)) >= DEPTH;
  endfunction

  // One clock: drive at the falling edge, check outputs, then advance the model.
  task automatic cycle(input bit rn, input bit fl, input bit rq, input logic [64:0] bus,
                       input logic [31:0] rd, input bit al);
    logic [96:0] exp_bus;
    logic [31:0] exp_inst;
    bit          exp_v;
    bit          exp_st;
    @(negedge clk);
    resetn          = rn;
    flush           = fl;
    fs_req_valid    = rq;
    fs_to_ds_bus    = bus;
    inst_sram_rdata = rd;
    ds_allowin      = al;
    #1;
    exp_v   = (mq.size() != 0) && !fl;
    exp_bus = (mq.size() != 0) ? mq[0] : '0;
    exp_st  = m_stall();
    chk("ds_valid", 97'(ds_valid), 97'(exp_v));
    chk("ds_bus", ds_bus, exp_bus);
    chk("fs_stall_req", 97'(fs_stall_req), 97'(exp_st));
    if (!rn) begin
      mq.delete();
      mpv = 1'b0;
      mpi = '0;
    end else if (fl) begin
      mq.delete();
      mpv = 1'b0;
      if (rq) mpi = bus;
    end else begin
      if (exp_v && al) void'(mq.pop_front());
      if (mpv) begin
        chk("no_overflow", 97'(mq.size() < DEPTH), 97'(1));
        exp_inst = mpi[32] ? 32'h0340_0000 : rd;
        if (mq.size() < DEPTH) mq.push_back({mpi[64:33], mpi[32], exp_inst, mpi[31:0]});
      end
      mpv = rq;
      if (rq) mpi = bus;
    end
  endtask

  initial begin
    int          issued;
    logic [31:0] pc;
    bit          rq;

    resetn          = 1'b0;
    flush           = 1'b0;
    fs_req_valid    = 1'b0;
    fs_to_ds_bus    = '0;
    inst_sram_rdata = '0;
    ds_allowin      = 1'b0;

    // Reset
    cycle(0, 0, 0, '0, 32'h0, 0);
    cycle(0, 0, 1, mkbus(32'h1, 0, 32'h5), 32'h1234, 1);
    chk("rst_ds_valid", 97'(ds_valid), 97'(0));
    chk("rst_ds_bus", ds_bus, 97'(0));
    chk("rst_stall", 97'(fs_stall_req), 97'(0));

    // 1. Streaming
    cycle(1, 0, 1, mkbus($urandom, 0, 32'h1c00_0000), $urandom, 1);
    chk("t1_lat0", 97'(ds_valid), 97'(0));
    cycle(1, 0, 1, mkbus($urandom, 0, 32'h1c00_0004), 32'haaaa_0001, 1);
    chk("t1_lat1", 97'(ds_valid), 97'(0));
    cycle(1, 0, 1, mkbus($urandom, 0, 32'h1c00_0008), 32'hbbbb_0002, 1);
    chk("t1_v0", 97'(ds_valid), 97'(1));
    chk("t1_pc0", 97'(ds_bus[31:0]), 97'(32'h1c00_0000));
    chk("t1_inst0", 97'(ds_bus[63:32]), 97'(32'haaaa_0001));
    cycle(1, 0, 0, '0, 32'hcccc_0003, 1);
    chk("t1_pc1", 97'(ds_bus[31:0]), 97'(32'h1c00_0004));
    chk("t1_inst1", 97'(ds_bus[63:32]), 97'(32'hbbbb_0002));
    cycle(1, 0, 0, '0, $urandom, 1);
    chk("t1_pc2", 97'(ds_bus[31:0]), 97'(32'h1c00_0008));
    chk("t1_inst2", 97'(ds_bus[63:32]), 97'(32'hcccc_0003));
    cycle(1, 0, 0, '0, $urandom, 1);
    chk("t1_empty", 97'(ds_valid), 97'(0));

    // 2. Back-pressure
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      rq = !m_stall();
      pc = 32'h1c00_0100 + 32'(4 * issued);
      cycle(1, 0, rq, mkbus($urandom, 0, pc), $urandom, 0);
      if (rq) issued++;
    end
    chk("t2_issued", 97'(issued), 97'(4));
    cycle(1, 0, 0, '0, $urandom, 0);
    chk("t2_stall", 97'(fs_stall_req), 97'(1));
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 0, '0, $urandom, 1);
      chk("t2_drain_pc", 97'(ds_bus[31:0]), 97'(32'h1c00_0100 + 32'(4 * k)));
    end
    cycle(1, 0, 0, '0, $urandom, 1);
    chk("t2_drained", 97'(ds_valid), 97'(0));

    // 3. Simultaneous push/pop at count 2
    cycle(1, 0, 1, mkbus($urandom, 0, 32'h1c00_0200), $urandom, 0);
    cycle(1, 0, 1, mkbus($urandom, 0, 32'h1c00_0204), $urandom, 0);
    cycle(1, 0, 1, mkbus($urandom, 0, 32'h1c00_0208), $urandom, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(1, 0, 1, mkbus($urandom, 0, 32'h1c00_020c + 32'(4 * k)), $urandom, 1);
      chk("t3_pc", 97'(ds_bus[31:0]), 97'(32'h1c00_0200 + 32'(4 * k)));
      chk("t3_nostall", 97'(fs_stall_req), 97'(0));
    end
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, '0, $urandom, 1);

    // 4. ADEF
    cycle(1, 0, 1, mkbus(32'hdead_beef, 1, 32'h1c00_0002), $urandom, 1);
    cycle(1, 0, 0, '0, 32'hffff_ffff, 1);
    cycle(1, 0, 0, '0, $urandom, 1);
    chk("t4_adef", 97'(ds_bus[64]), 97'(1));
    chk("t4_inst", 97'(ds_bus[63:32]), 97'(32'h0340_0000));
    chk("t4_pc", 97'(ds_bus[31:0]), 97'(32'h1c00_0002));
    chk("t4_csr", 97'(ds_bus[96:65]), 97'(32'hdead_beef));

    // 5. Flush with 3 queued and one pending
    for (int k = 0; k < 4; k++) cycle(1, 0, 1, mkbus($urandom, 0, 32'h1c00_0300 + 32'(4 * k)), $urandom, 0);
    cycle(1, 1, 1, mkbus($urandom, 0, 32'h1c00_0400), $urandom, 1);
    chk("t5_flush_valid", 97'(ds_valid), 97'(0));
    cycle(1, 0, 1, mkbus($urandom, 0, 32'h1c00_1000), $urandom, 1);
    chk("t5_post_valid", 97'(ds_valid), 97'(0));
    chk("t5_post_stall", 97'(fs_stall_req), 97'(0));
    cycle(1, 0, 0, '0, 32'h1111_2222, 1);
    chk("t5_lat1", 97'(ds_valid), 97'(0));
    cycle(1, 0, 0, '0, $urandom, 1);
    chk("t5_redirect_v", 97'(ds_valid), 97'(1));
    chk("t5_redirect_pc", 97'(ds_bus[31:0]), 97'(32'h1c00_1000));
    chk("t5_redirect_inst", 97'(ds_bus[63:32]), 97'(32'h1111_2222));
    cycle(1, 0, 0, '0, $urandom, 1);
    chk("t5_sole", 97'(ds_valid), 97'(0));

    // 6. Reset mid-stream
    for (int k = 0; k < 3; k++) cycle(1, 0, 1, mkbus($urandom, 0, 32'h1c00_0500 + 32'(4 * k)), $urandom, 0);
    cycle(0, 0, 0, '0, $urandom, 0);
    cycle(1, 0, 0, '0, $urandom, 1);
    chk("t6_valid", 97'(ds_valid), 97'(0));
    chk("t6_bus", ds_bus, 97'(0));
    chk("t6_stall", 97'(fs_stall_req), 97'(0));
    cycle(1, 0, 0, '0, $urandom, 1);
    chk("t6_stale", 97'(ds_valid), 97'(0));

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      rq = ($urandom_range(3) != 0) && !m_stall();
      cycle($urandom_range(63) != 0, $urandom_range(15) == 0, rq,
            mkbus($urandom, $urandom_range(7) == 0, $urandom), $urandom,
            $urandom_range(3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
